rv_multicycle_datapath: RTL and testbench
=========================================

Name: rv_multicycle_datapath

Overview:
- Parametrised multi-cycle successor to the single-cycle RV32I datapath.
- Executes R-type and I-type ALU instructions through a FETCH/DECODE/EXECUTE/WRITEBACK state machine.
- Handles instruction memory with a req/valid handshake, so wait states are supported.
- Owns the PC, an x0-hardwired register file, and the IR/A/B/ALUOut pipeline registers. An external control unit decodes the ir output and drives the ALU controls.

Parameters:
XLEN, 32, datapath width in bits (32 or 64).
NREG, 32, number of architectural registers (16 or 32). Register address width is log2(NREG).
RESET_PC, 0, PC value loaded on reset.
PC_STEP, 4, PC increment per retired instruction.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
instr_req  output  1  instruction fetch request.
instr_addr  output  XLEN  fetch address (current PC).
instr_valid  input  1  instruction data valid; completes the fetch.
instr_rdata  input  32  instruction word.
ir  output  32  latched instruction, for the external decoder.
alu_control  input  4  ALU operation select, sampled in EXECUTE.
alu_src_imm  input  1  1 = operand B is the sign-extended ir[31:20]; 0 = rs2 data. Sampled in EXECUTE.
reg_write_en  input  1  write rd in WRITEBACK. Sampled in WRITEBACK.
retire  output  1  one-cycle pulse in the WRITEBACK cycle.
busy  output  1  high in every state except FETCH.
dbg_raddr  input  log2(NREG)  debug read address.
dbg_rdata  output  XLEN  debug read data (combinational; x0 reads 0).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH, PC=RESET_PC, all registers=0.
  - IR, A, B, ALUOut = 0.
  - instr_req=0, retire=0, busy=0.
  - On release, instr_req rises on the first clock edge.
  - Reset asserted in any state aborts the instruction: no register write, no retire.
- FETCH:
  - instr_req=1 and instr_addr=PC, both held stable until a cycle with instr_valid=1.
  - On that edge: IR<=instr_rdata, go to DECODE, instr_req drops.
  - instr_valid in any other state is ignored.
- DECODE:
  - A<=reg[IR[19:15]], B<=reg[IR[24:20]]. Goes to EXECUTE.
  - Register indices are truncated to log2(NREG) bits.
- EXECUTE:
  - ALUOut<=ALU(A, opB, alu_control). Goes to WRITEBACK.
  - opB = alu_src_imm ? sign-extended IR[31:20] : B.
- WRITEBACK:
  - If reg_write_en and rd (IR[11:7]) != 0: reg[rd]<=ALUOut.
  - PC<=PC+PC_STEP, modulo 2^XLEN (wraps silently).
  - retire=1 for this cycle only. Goes to FETCH.
- Minimum latency is 4 cycles per instruction. Each FETCH wait cycle adds 1.
- A register write is visible on dbg_rdata the cycle after WRITEBACK.
- x0: writes are discarded; reads always return 0.
- ALU codes:
  - 0000 add, 1000 sub, 0001 sll, 0101 srl, 1101 sra.
  - 0010 slt (signed), 0011 sltu, 0100 xor, 0110 or, 0111 and.
  - Any other code gives 0.
  - Shift amount = opB[log2(XLEN)-1:0].
  - sra is arithmetic, sign-filled.
- No traps, branches, or loads/stores. Unsupported opcodes execute whatever alu_control selects.

Test Plan:
- Addi: reset, then instr 0x00500093 (addi x1,x0,5), control add, imm=1, we=1 -> retire at the 4th cycle after req, x1=5, PC=4.
- Wait states: instr_valid delayed 3 cycles -> instr_req and instr_addr held stable, retire at the 7th cycle, result identical.
- x0 protection: addi x0,x0,7 (0x00700013) with we=1 -> dbg read x0=0, retire still pulses, PC advances.
- Signed ops:
  - x1=-16 via 0xFF000093.
  - srai x2,x1,2 (0x4020D113, code 1101, imm) -> x2=0xFFFFFFFC.
  - slt x3,x1,x0 -> 1; sltu x4,x1,x0 -> 0.
- Reset mid-instruction: drop reset during EXECUTE -> immediately state=FETCH, PC=0, no retire, all registers 0 after release.
- PC wrap: RESET_PC=0xFFFFFFFC, one instruction -> PC=0x00000000 after retire.

Source files
------------

// File: rtl/rv_multicycle_datapath.sv
// -----------------------------------------------------------------------------
// rv_multicycle_datapath
//
// Multi-cycle RV32I/RV64I ALU datapath. Each instruction walks through
// FETCH -> DECODE -> EXECUTE -> WRITEBACK. The block owns the PC, an
// x0-hardwired register file and the IR/A/B/ALUOut holding registers. An
// external control unit decodes `ir` and drives the ALU controls.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   instr_req     instruction fetch request (registered)
//   instr_addr    fetch address, equal to the current PC
//   instr_valid   instruction data valid, completes a pending fetch
//   instr_rdata   instruction word
//   ir            latched instruction for the external decoder
//   alu_control   ALU operation select, sampled in EXECUTE
//   alu_src_imm   1: operand B is sign-extended ir[31:20]; 0: rs2 data
//   reg_write_en  write rd in WRITEBACK
//   retire        one-cycle pulse during the WRITEBACK cycle (registered)
//   busy          high in every state except FETCH (registered)
//   dbg_raddr     debug register read address
//   dbg_rdata     debug register read data (combinational, x0 reads 0)
// -----------------------------------------------------------------------------
module rv_multicycle_datapath #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    instr_req,
  output logic [XLEN-1:0]         instr_addr,
  input  logic                    instr_valid,
  input  logic [31:0]             instr_rdata,
  output logic [31:0]             ir,
  input  logic [3:0]              alu_control,
  input  logic                    alu_src_imm,
  input  logic                    reg_write_en,
  output logic                    retire,
  output logic                    busy,
  input  logic [$clog2(NREG)-1:0] dbg_raddr,
  output logic [XLEN-1:0]         dbg_rdata
);

  localparam int unsigned     AW      = $clog2(NREG);
  localparam int unsigned     SW      = $clog2(XLEN);
  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] PC_INC  = XLEN'(PC_STEP);
  localparam logic [AW-1:0]   REG_X0  = {AW{1'b0}};

  // ALU operation codes
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_t;

  // ALU: unknown codes deliberately yield zero so an undecoded instruction
  // cannot leak stale operand data into the register file.
  function automatic logic [XLEN-1:0] alu_f(
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic [3:0]      op
  );
    logic [SW-1:0]   shamt;
    logic [XLEN-1:0] res;
    shamt = b[SW-1:0];
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SLL:  res = a << shamt;
      OP_SRL:  res = a >> shamt;
      OP_SRA:  res = XLEN'($signed(a) >>> shamt);
      OP_SLT:  res = ($signed(a) < $signed(b)) ? ONE : ZERO;
      OP_SLTU: res = (a < b) ? ONE : ZERO;
      OP_XOR:  res = a ^ b;
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      default: res = ZERO;
    endcase
    return res;
  endfunction

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic [31:0]     ir_r;
  logic [XLEN-1:0] a_r;
  logic [XLEN-1:0] b_r;
  logic [XLEN-1:0] alu_out_r;
  logic            req_r;
  logic            retire_r;
  logic            busy_r;
  logic [XLEN-1:0] rf_r [NREG];

  logic [AW-1:0]   rs1_s;
  logic [AW-1:0]   rs2_s;
  logic [AW-1:0]   rd_s;
  logic [XLEN-1:0] rs1_data_s;
  logic [XLEN-1:0] rs2_data_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] opb_s;
  logic [XLEN-1:0] alu_res_s;
  logic            rf_we_s;

  // Register indices are truncated to the register-file address width.
  assign rs1_s = ir_r[15 +: AW];
  assign rs2_s = ir_r[20 +: AW];
  assign rd_s  = ir_r[7 +: AW];
  assign imm_s = {{(XLEN-12){ir_r[31]}}, ir_r[31:20]};

  // Register-file read ports; x0 is forced to zero on every read.
  always_comb begin
    rs1_data_s = ZERO;
    rs2_data_s = ZERO;
    dbg_rdata  = ZERO;
    if (rs1_s == REG_X0) begin
      rs1_data_s = ZERO;
    end else begin
      rs1_data_s = rf_r[rs1_s];
    end
    if (rs2_s == REG_X0) begin
      rs2_data_s = ZERO;
    end else begin
      rs2_data_s = rf_r[rs2_s];
    end
    if (dbg_raddr == REG_X0) begin
      dbg_rdata = ZERO;
    end else begin
      dbg_rdata = rf_r[dbg_raddr];
    end
  end

  // Operand B select and ALU evaluation for the EXECUTE step.
  always_comb begin
    opb_s = b_r;
    if (alu_src_imm) begin
      opb_s = imm_s;
    end else begin
      opb_s = b_r;
    end
    alu_res_s = alu_f(a_r, opb_s, alu_control);
  end

  // Register-file write enable: only in WRITEBACK, never to x0.
  always_comb begin
    rf_we_s = 1'b0;
    if ((state_r == S_WRITEBACK) && reg_write_en && (rd_s != REG_X0)) begin
      rf_we_s = 1'b1;
    end else begin
      rf_we_s = 1'b0;
    end
  end

  // Register file storage; cleared by reset so a fresh start reads all zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        rf_r[i] <= ZERO;
      end
    end else if (rf_we_s) begin
      rf_r[rd_s] <= alu_out_r;
    end
  end

  // Control FSM plus PC/IR/A/B/ALUOut and the registered handshake outputs.
  // The outputs are loaded with the values that belong to the next state so
  // they are glitch-free and line up with that state's cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_FETCH;
      pc_r      <= RESET_PC;
      ir_r      <= 32'h0000_0000;
      a_r       <= ZERO;
      b_r       <= ZERO;
      alu_out_r <= ZERO;
      req_r     <= 1'b0;
      retire_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          // The request first rises one edge after reset; a fetch only
          // completes while the request is actually visible.
          req_r    <= 1'b1;
          retire_r <= 1'b0;
          busy_r   <= 1'b0;
          if (req_r && instr_valid) begin
            ir_r    <= instr_rdata;
            req_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_r     <= rs1_data_s;
          b_r     <= rs2_data_s;
          state_r <= S_EXECUTE;
        end
        S_EXECUTE: begin
          alu_out_r <= alu_res_s;
          retire_r  <= 1'b1;
          state_r   <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          // PC wraps silently at 2^XLEN. Raising the request here lets
          // back-to-back fetches run at four cycles per instruction.
          pc_r     <= pc_r + PC_INC;
          retire_r <= 1'b0;
          busy_r   <= 1'b0;
          req_r    <= 1'b1;
          state_r  <= S_FETCH;
        end
        default: begin
          state_r  <= S_FETCH;
          req_r    <= 1'b0;
          retire_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign instr_req  = req_r;
  assign instr_addr = pc_r;
  assign ir         = ir_r;
  assign retire     = retire_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_rv_multicycle_datapath.sv
module tb_rv_multicycle_datapath;

  logic        clk;
  logic        reset;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic [31:0] instr_rdata;
  logic [31:0] ir;
  logic [3:0]  alu_control;
  logic        alu_src_imm;
  logic        reg_write_en;
  logic        retire;
  logic        busy;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  // second instance, reset PC near the top of the address space
  logic        w_instr_req;
  logic [31:0] w_instr_addr;
  logic [31:0] w_ir;
  logic        w_retire;
  logic        w_busy;
  logic [31:0] w_dbg_rdata;

  rv_multicycle_datapath #(.XLEN(32), .NREG(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .reset(reset), .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_rdata(instr_rdata), .ir(ir),
    .alu_control(alu_control), .alu_src_imm(alu_src_imm), .reg_write_en(reg_write_en),
    .retire(retire), .busy(busy), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  rv_multicycle_datapath #(.XLEN(32), .NREG(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) u_wrap (
    .clk(clk), .reset(reset), .instr_req(w_instr_req), .instr_addr(w_instr_addr),
    .instr_valid(instr_valid), .instr_rdata(instr_rdata), .ir(w_ir),
    .alu_control(alu_control), .alu_src_imm(alu_src_imm), .reg_write_en(reg_write_en),
    .retire(w_retire), .busy(w_busy), .dbg_raddr(dbg_raddr), .dbg_rdata(w_dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rf [32];
  logic [31:0] model_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference ALU written with 64-bit arithmetic
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    int unsigned sh;
    longint      sa;
    longint      sbv;
    longint      ua;
    longint      ub;
    sh  = b % 32;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    case (c)
      4'h0:    return 32'(ua + ub);
      4'h8:    return 32'(ua - ub);
      4'h1:    return 32'(ua << sh);
      4'h5:    return 32'(ua >> sh);
      4'hD:    return 32'(sa >>> sh);
      4'h2:    return (sa < sbv) ? 32'd1 : 32'd0;
      4'h3:    return (ua < ub) ? 32'd1 : 32'd0;
      4'h4:    return a ^ b;
      4'h6:    return a | b;
      4'h7:    return a & b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    model_pc = 32'd0;
  endtask

  task automatic check_reg(input logic [4:0] r, input logic [31:0] v);
    dbg_raddr = r;
    #1;
    check($sformatf("reg_x%0d", r), dbg_rdata, v);
  endtask

  // One full instruction with `waits` stall cycles before instr_valid.
  task automatic issue(input logic [31:0] instr, input logic [3:0] ctl, input logic imm,
                       input logic we, input int waits);
    int          n;
    int          cyc;
    exp_t        e;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [4:0]  rd;
    n = 0;
    while (instr_req !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    check("req_seen", instr_req, 1);
    cyc = 1;
    instr_valid = 1'b0;
    for (int w = 0; w < waits; w++) begin
      check("fetch_hold_req", instr_req, 1);
      check("fetch_hold_addr", instr_addr, model_pc);
      check("fetch_busy", busy, 0);
      tick();
      cyc++;
    end
    check("fetch_addr", instr_addr, model_pc);
    instr_valid  = 1'b1;
    instr_rdata  = instr;
    alu_control  = ctl;
    alu_src_imm  = imm;
    reg_write_en = we;
    rd           = instr[11:7];
    dbg_raddr    = rd;
    // model step
    a = model_rf[instr[19:15]];
    b = imm ? {{20{instr[31]}}, instr[31:20]} : model_rf[instr[24:20]];
    r = ref_alu(a, b, ctl);
    if (we && rd != 5'd0) model_rf[rd] = r;
    e.pc  = model_pc;
    e.ir  = instr;
    e.val = model_rf[rd];
    sb.push_back(e);
    model_pc = model_pc + 32'd4;
    tick();
    cyc++;
    check("busy_decode", busy, 1);
    check("req_drop", instr_req, 0);
    // valid outside FETCH must be ignored
    while (retire !== 1'b1 && cyc < waits + 12) begin
      instr_valid = 1'($urandom_range(0, 1));
      instr_rdata = $urandom;
      tick();
      cyc++;
    end
    check("retire_latency", cyc, waits + 4);
    instr_valid = 1'b0;
    tick();
    check("retire_single", retire, 0);
    check("pc_next", instr_addr, model_pc);
  endtask

  // Scoreboard monitor: compare each retirement, then the written register.
  initial begin : monitor
    exp_t        e;
    bit          pend;
    logic [31:0] pv;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("dbg_after_wb", dbg_rdata, pv);
        pend = 1'b0;
      end
      if (retire === 1'b1) begin
        if (sb.size() == 0) begin
          check("retire_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("retire_pc", instr_addr, e.pc);
          check("retire_ir", ir, e.ir);
          pv   = e.val;
          pend = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  logic [3:0] codes [10];

  initial begin : stim
    logic [3:0] c;
    codes = '{4'h0, 4'h8, 4'h1, 4'h5, 4'hD, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7};
    reset = 1'b0; instr_valid = 1'b0; instr_rdata = 32'd0; alu_control = 4'd0;
    alu_src_imm = 1'b0; reg_write_en = 1'b0; dbg_raddr = 5'd0;
    model_reset();
    tick(); tick();
    check("rst_req", instr_req, 0);
    check("rst_retire", retire, 0);
    check("rst_busy", busy, 0);
    check("rst_pc", instr_addr, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_wrap_pc", w_instr_addr, 32'hFFFF_FFFC);
    check_reg(5'd1, 32'd0);
    reset = 1'b1;
    tick();
    check("req_after_release", instr_req, 1);

    // addi x1,x0,5, no wait states
    issue(32'h0050_0093, 4'h0, 1'b1, 1'b1, 0);
    check_reg(5'd1, 32'd5);
    check("pc_after_addi", instr_addr, 32'd4);
    check("wrap_pc", w_instr_addr, 32'd0);
    // same with three wait states
    issue(32'h0050_0093, 4'h0, 1'b1, 1'b1, 3);
    check_reg(5'd1, 32'd5);
    // x0 protection
    issue(32'h0070_0013, 4'h0, 1'b1, 1'b1, 1);
    check_reg(5'd0, 32'd0);
    check("pc_after_x0", instr_addr, 32'd12);
    // signed operations
    issue(32'hFF00_0093, 4'h0, 1'b1, 1'b1, 0);
    check_reg(5'd1, 32'hFFFF_FFF0);
    issue(32'h4020_D113, 4'hD, 1'b1, 1'b1, 2);
    check_reg(5'd2, 32'hFFFF_FFFC);
    issue(32'h0000_A1B3, 4'h2, 1'b0, 1'b1, 0);
    check_reg(5'd3, 32'd1);
    issue(32'h0000_B233, 4'h3, 1'b0, 1'b1, 0);
    check_reg(5'd4, 32'd0);

    // randomized instructions
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 4) == 0) c = 4'($urandom_range(0, 15));
      else c = codes[$urandom_range(0, 9)];
      issue($urandom, c, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
    end

    // reset during EXECUTE
    while (instr_req !== 1'b1) tick();
    instr_valid = 1'b1; instr_rdata = 32'h0050_0093; alu_control = 4'h0;
    alu_src_imm = 1'b1; reg_write_en = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    check("busy_execute", busy, 1);
    reset = 1'b0;
    #1;
    check("midrst_req", instr_req, 0);
    check("midrst_busy", busy, 0);
    check("midrst_retire", retire, 0);
    check("midrst_pc", instr_addr, 32'd0);
    check("midrst_ir", ir, 32'd0);
    tick(); tick();
    check("midrst_no_retire", retire, 0);
    model_reset();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) check_reg(5'(i), 32'd0);
    tick();
    check("req_after_midrst", instr_req, 1);
    for (int k = 0; k < 6; k++) begin
      issue($urandom, codes[$urandom_range(0, 9)], 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 2));
    end

    tick(); tick();
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
